sdf_march_scheduler: RTL and testbench
======================================

// Module: sdf_march_scheduler
// PURPOSE
//  Shares one fixed-latency, fully pipelined SDF evaluator (scene sdf block) among
//  N ray-march requesters. Arbitrates round-robin, issues at most one point per cycle
//  and tags each issue with its requester ID. Returns each distance to its originator
//  after the fixed pipeline latency.
//  Owns the scene repetition_pow config, changed only when the pipeline is drained.
// PARAMETERS
//  N_REQ        4   number of requesters (2..8)
//  SDF_LATENCY  12  cycles from sdf point inputs to matching distance output (>=1)
//  RESET_POW    4'd2 repetition_pow value applied at reset
// PORTS
//  clk             in   1        clock, all state on rising edge
//  rst_n           in   1        async active-low reset
//  req_valid       in   N_REQ    requester i has a point to evaluate (level, held until granted)
//  req_point_x/y/z in   27*N_REQ fp27 points, requester i at bits [27*i+:27]
//  req_grant       out  N_REQ    one-hot pulse, point i accepted this cycle
//  sdf_point_x/y/z out  27       registered point driven into sdf
//  sdf_pow         out  4        repetition_pow driven into sdf
//  sdf_distance    in   27       sdf result, valid SDF_LATENCY cycles after point
//  resp_valid      out  N_REQ    one-hot pulse, resp_distance belongs to requester i
//  resp_distance   out  27       fp27 distance (combinational from sdf_distance)
//  cfg_valid       in   1        request to load cfg_pow (level, held until cfg_ack)
//  cfg_pow         in   4        new repetition_pow
//  cfg_ack         out  1        one-cycle pulse, cfg_pow now applied
//  busy            out  1        any evaluation in flight or state != RUN
// BEHAVIOUR
//  Reset: req_grant=0, resp_valid=0, cfg_ack=0, sdf_point_*=0, sdf_pow=RESET_POW,
//   outstanding=0, tag pipe cleared, rr pointer=0, state=RUN. Results in flight at
//   reset are discarded (sdf itself has no reset; its output is ignored via tags).
//  Eligibility: elig[i] = req_valid[i] & ~outstanding[i] (registered outstanding).
//   Each requester has at most one evaluation in flight.
//  Arbitration (state RUN only): grant first eligible index at or after rr pointer,
//   wrapping modulo N_REQ; on grant, rr pointer <= granted+1 (wraps to 0).
//   Zero or one grant per cycle.
//  Issue: grant in cycle t -> sdf_point_* = granted point from t+1; tag pipe stage 0
//   at t+1 = {valid=1,id}; no grant -> stage 0 valid=0, sdf_point_* holds last value.
//  Tag pipe: SDF_LATENCY stages of {valid, id}, shifts every cycle, no stall.
//   Last stage drives resp_valid = valid ? onehot(id) : 0.
//   Grant at t => resp_valid at t+1+SDF_LATENCY.
//  outstanding[i]: set on req_grant[i], cleared on resp_valid[i]. Requester i is
//   eligible again at the cycle after its resp_valid.
//  FSM:
//   RUN:   cfg_valid=1 -> DRAIN (no grant in the cycle cfg_valid is seen).
//   DRAIN: no grants; when tag pipe all-invalid -> APPLY.
//   APPLY: sdf_pow <= cfg_pow, cfg_ack=1 for this one cycle, -> RUN.
//  cfg_valid held high after cfg_ack: treated as a new request (re-drains).
//  cfg_valid while pipe already empty: DRAIN lasts one cycle.
//  busy = (state!=RUN) | (|outstanding).
//  No arithmetic on fp27 data; points and distances pass through bit-exact.
// TESTING
//  1 Reset then idle: sdf_pow=2, all grants/resp 0, busy=0 for 20 cycles.
//  2 Single req: req_valid=4'b0100 at t -> req_grant=0100 at t, sdf_point=req2 point
//    at t+1, resp_valid=0100 at t+13 with resp_distance=sdf_distance, busy low after.
//  3 All four requesting continuously (rr=0) -> grants 0,1,2,3 on consecutive cycles;
//    resp order 0,1,2,3; each requester re-granted only after its own resp.
//  4 cfg_valid with 3 in flight, cfg_pow=5 -> no grants until last resp, then one
//    DRAIN->APPLY, cfg_ack pulse, sdf_pow=5, grants resume next cycle.
//  5 rst_n low mid-flight (2 in flight) -> outputs to reset values immediately; no
//    resp_valid in the following SDF_LATENCY cycles despite sdf_distance toggling.
//  6 Requester 3 drops and reasserts req_valid while requesters 0,1 stream -> rr wrap
//    from 3 to 0 correct, no requester starved beyond N_REQ grant slots.

Source files
------------

// File: rtl/sdf_march_scheduler.sv
// Round-robin scheduler sharing one fixed-latency SDF evaluator among N ray-march requesters.
// Tags each issued point with its requester ID and routes the distance back after the pipeline latency.
module sdf_march_scheduler #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned SDF_LATENCY = 12,
    parameter logic [3:0]  RESET_POW   = 4'd2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [27*N_REQ-1:0]   req_point_x,
    input  logic [27*N_REQ-1:0]   req_point_y,
    input  logic [27*N_REQ-1:0]   req_point_z,
    output logic [N_REQ-1:0]      req_grant,
    output logic [26:0]           sdf_point_x,
    output logic [26:0]           sdf_point_y,
    output logic [26:0]           sdf_point_z,
    output logic [3:0]            sdf_pow,
    input  logic [26:0]           sdf_distance,
    output logic [N_REQ-1:0]      resp_valid,
    output logic [26:0]           resp_distance,
    input  logic                  cfg_valid,
    input  logic [3:0]            cfg_pow,
    output logic                  cfg_ack,
    output logic                  busy
);
    localparam int unsigned FP_W  = 27;
    localparam int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned TAG_W = SDF_LATENCY * ID_W;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        APPLY = 2'd2
    } state_t;

    state_t                   state;
    logic [ID_W-1:0]          rr;
    logic [N_REQ-1:0]         outstanding;
    logic [SDF_LATENCY-1:0]   tag_v;
    logic [TAG_W-1:0]         tag_id;

    logic [N_REQ-1:0]         elig;
    logic [ID_W-1:0]          cand;
    logic [ID_W-1:0]          grant_id;
    logic                     grant_any;
    logic [ID_W-1:0]          last_id;
    logic [FP_W-1:0]          sel_x;
    logic [FP_W-1:0]          sel_y;
    logic [FP_W-1:0]          sel_z;

    assign elig    = req_valid & ~outstanding;
    assign last_id = tag_id[(SDF_LATENCY-1)*ID_W +: ID_W];

    // First eligible requester at or after the round-robin pointer; none while draining or on a cfg request.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        cand      = '0;
        if (state == RUN && !cfg_valid) begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                if (32'(rr) + k >= N_REQ) begin
                    cand = ID_W'(32'(rr) + k - N_REQ);
                end else begin
                    cand = ID_W'(32'(rr) + k);
                end
                if (!grant_any && elig[cand]) begin
                    grant_any = 1'b1;
                    grant_id  = cand;
                end
            end
        end
    end

    assign req_grant = grant_any ? (N_REQ'(1) << grant_id) : '0;

    assign sel_x = req_point_x[32'(grant_id)*FP_W +: FP_W];
    assign sel_y = req_point_y[32'(grant_id)*FP_W +: FP_W];
    assign sel_z = req_point_z[32'(grant_id)*FP_W +: FP_W];

    assign resp_distance = sdf_distance;
    assign busy          = (state != RUN) | (|outstanding);

    // Tag pipe aligned with the SDF pipeline plus one output register stage matching the issue register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            rr          <= '0;
            outstanding <= '0;
            tag_v       <= '0;
            tag_id      <= '0;
            resp_valid  <= '0;
            cfg_ack     <= 1'b0;
            sdf_pow     <= RESET_POW;
            sdf_point_x <= '0;
            sdf_point_y <= '0;
            sdf_point_z <= '0;
        end else begin
            tag_v       <= SDF_LATENCY'({tag_v, grant_any});
            tag_id      <= TAG_W'({tag_id, grant_id});
            resp_valid  <= tag_v[SDF_LATENCY-1] ? (N_REQ'(1) << last_id) : '0;
            outstanding <= (outstanding | req_grant) & ~resp_valid;
            cfg_ack     <= 1'b0;

            if (grant_any) begin
                sdf_point_x <= sel_x;
                sdf_point_y <= sel_y;
                sdf_point_z <= sel_z;
                rr          <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
            end

            case (state)
                RUN: begin
                    if (cfg_valid) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (tag_v == '0) begin
                        state   <= APPLY;
                        cfg_ack <= 1'b1;
                    end
                end
                APPLY: begin
                    sdf_pow <= cfg_pow;
                    state   <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_sdf_march_scheduler.sv
// Randomized scoreboard bench for sdf_march_scheduler with a delay-line SDF stand-in.
module tb_sdf_march_scheduler;
    localparam int unsigned N = 4;
    localparam int unsigned L = 12;
    localparam int unsigned W = 27;
    localparam int PH_RUN   = 0;
    localparam int PH_DRAIN = 1;
    localparam int PH_APPLY = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [N-1:0]     req_valid;
    logic [W*N-1:0]   req_point_x, req_point_y, req_point_z;
    logic [N-1:0]     req_grant;
    logic [W-1:0]     sdf_point_x, sdf_point_y, sdf_point_z;
    logic [3:0]       sdf_pow;
    logic [W-1:0]     sdf_distance;
    logic [N-1:0]     resp_valid;
    logic [W-1:0]     resp_distance;
    logic             cfg_valid;
    logic [3:0]       cfg_pow;
    logic             cfg_ack;
    logic             busy;

    always #5 clk = ~clk;

    sdf_march_scheduler #(.N_REQ(N), .SDF_LATENCY(L), .RESET_POW(4'd2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid),
        .req_point_x(req_point_x), .req_point_y(req_point_y), .req_point_z(req_point_z),
        .req_grant(req_grant),
        .sdf_point_x(sdf_point_x), .sdf_point_y(sdf_point_y), .sdf_point_z(sdf_point_z),
        .sdf_pow(sdf_pow), .sdf_distance(sdf_distance),
        .resp_valid(resp_valid), .resp_distance(resp_distance),
        .cfg_valid(cfg_valid), .cfg_pow(cfg_pow), .cfg_ack(cfg_ack), .busy(busy)
    );

    function automatic logic [W-1:0] sdf_fn(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic [W-1:0] z);
        return x ^ {y[13:0], y[26:14]} ^ ~z;
    endfunction

    // Stand-in evaluator: pure delay line of L cycles, no reset.
    logic [W-1:0] px [L];
    logic [W-1:0] py [L];
    logic [W-1:0] pz [L];
    always @(posedge clk) begin
        for (int k = int'(L) - 1; k > 0; k--) begin
            px[k] <= px[k-1];
            py[k] <= py[k-1];
            pz[k] <= pz[k-1];
        end
        px[0] <= sdf_point_x;
        py[0] <= sdf_point_y;
        pz[0] <= sdf_point_z;
    end
    assign sdf_distance = sdf_fn(px[L-1], py[L-1], pz[L-1]);

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int           id;
        int           due;
        logic [W-1:0] d;
    } exp_t;

    exp_t         sbq[$];
    logic [N-1:0] m_out;
    int           m_rr;
    int           m_phase;
    logic [3:0]   m_pow;
    logic [W-1:0] m_px, m_py, m_pz;
    logic [N-1:0] exp_g;
    int           gid;
    exp_t         e;

    // Monitor: reference model of the arbitration/config rules plus response scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete();
            m_out = '0; m_rr = 0; m_phase = PH_RUN; m_pow = 4'd2;
            m_px = '0; m_py = '0; m_pz = '0;
            check("rst_grant", 32'(req_grant), 32'd0);
            check("rst_resp", 32'(resp_valid), 32'd0);
            check("rst_ack", 32'(cfg_ack), 32'd0);
            check("rst_pow", 32'(sdf_pow), 32'd2);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_point", 32'(sdf_point_x | sdf_point_y | sdf_point_z), 32'd0);
        end else begin
            check("point_x", 32'(sdf_point_x), 32'(m_px));
            check("point_y", 32'(sdf_point_y), 32'(m_py));
            check("point_z", 32'(sdf_point_z), 32'(m_pz));

            gid   = -1;
            exp_g = '0;
            if (m_phase == PH_RUN && !cfg_valid) begin
                for (int k = 0; k < int'(N); k++) begin
                    int i;
                    i = (m_rr + k) % int'(N);
                    if (gid < 0 && req_valid[i] && !m_out[i]) gid = i;
                end
            end
            if (gid >= 0) exp_g[gid] = 1'b1;
            check("grant", 32'(req_grant), 32'(exp_g));
            check("cfg_ack", 32'(cfg_ack), 32'(m_phase == PH_APPLY));
            check("sdf_pow", 32'(sdf_pow), 32'(m_pow));
            check("busy", 32'(busy), 32'((m_phase != PH_RUN) || (m_out != '0)));

            if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                e = sbq.pop_front();
                check("resp_valid", 32'(resp_valid), 32'(1) << e.id);
                check("resp_distance", 32'(resp_distance), 32'(e.d));
                m_out[e.id] = 1'b0;
            end else begin
                check("resp_idle", 32'(resp_valid), 32'd0);
            end

            if (gid >= 0) begin
                m_out[gid] = 1'b1;
                m_rr = (gid + 1) % int'(N);
                m_px = req_point_x[gid*W +: W];
                m_py = req_point_y[gid*W +: W];
                m_pz = req_point_z[gid*W +: W];
                sbq.push_back('{gid, cyc + 1 + int'(L), sdf_fn(m_px, m_py, m_pz)});
            end

            case (m_phase)
                PH_RUN:   if (cfg_valid) m_phase = PH_DRAIN;
                PH_DRAIN: if (sbq.size() == 0) m_phase = PH_APPLY;
                default: begin
                    m_pow   = cfg_pow;
                    m_phase = PH_RUN;
                end
            endcase
        end
    end

    logic       last_ack = 1'b0;
    logic       cfg_go = 1'b0;
    logic [3:0] cfg_val = 4'd0;

    // One stimulus cycle: granted requesters get a fresh point, masked-off ones withdraw.
    task automatic drive(input logic [N-1:0] mask, input int pct);
        logic [N-1:0] g;
        @(negedge clk);
        g = req_grant;
        last_ack = cfg_ack;
        @(posedge clk);
        #1;
        if (cfg_valid && last_ack) begin
            cfg_valid = 1'b0;
        end else if (cfg_go && !cfg_valid) begin
            cfg_valid = 1'b1;
            cfg_pow   = cfg_val;
            cfg_go    = 1'b0;
        end
        for (int i = 0; i < int'(N); i++) begin
            if (req_valid[i] && (g[i] || !mask[i])) req_valid[i] = 1'b0;
            if (!req_valid[i] && mask[i] && int'($urandom_range(99)) < pct) begin
                req_valid[i] = 1'b1;
                req_point_x[i*W +: W] = W'($urandom);
                req_point_y[i*W +: W] = W'($urandom);
                req_point_z[i*W +: W] = W'($urandom);
            end
        end
    endtask

    task automatic do_cfg(input logic [3:0] pow, input logic [N-1:0] mask, input int pct);
        int n;
        logic got;
        cfg_go  = 1'b1;
        cfg_val = pow;
        n   = 0;
        got = 1'b0;
        while (!got && n < 300) begin
            drive(mask, pct);
            got = last_ack;
            n++;
        end
        check("cfg_ack_seen", 32'(got), 32'd1);
    endtask

    initial begin
        req_valid = '0;
        req_point_x = '0; req_point_y = '0; req_point_z = '0;
        cfg_valid = 1'b0;
        cfg_pow   = 4'd0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        repeat (20) drive('0, 0);
        drive(4'b0100, 100);
        repeat (L + 6) drive('0, 0);
        repeat (60) drive(4'b1111, 100);
        repeat (3) drive(4'b0111, 100);
        do_cfg(4'd5, 4'b1111, 100);
        repeat (30) drive(4'b1111, 100);
        repeat (L + 4) drive('0, 0);
        do_cfg(4'd9, '0, 0);

        repeat (4) drive(4'b0011, 100);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req_valid = '0;
        cfg_valid = 1'b0;
        cfg_go = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (L + 4) drive('0, 0);

        for (int c = 0; c < 200; c++) drive({1'($urandom), 1'b0, 2'b11}, 100);

        for (int c = 0; c < 1200; c++) begin
            if ($urandom_range(99) < 2) do_cfg(4'($urandom), 4'($urandom), int'($urandom_range(30, 100)));
            else drive(4'($urandom), int'($urandom_range(20, 100)));
        end
        repeat (L + 6) drive('0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end
endmodule
